// File: rtl/rot_pkg.sv
// Shared defaults and FSM encoding for the rotator front-end loader.
package rot_pkg;

   localparam int N_DEFAULT      = 2048;
   localparam int LOG2_N_DEFAULT = 11;
   localparam int W_DEFAULT      = 64;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      HOLD = 2'd2
   } rot_state_e;

   function automatic int beats_per_word(input int n, input int w);
      return n / w;
   endfunction

endpackage

// File: rtl/rot_beat_ctr.sv
// Beat index counter: clear, enable, wrap at B-1, flags the last beat.
module rot_beat_ctr #(
   parameter int B  = 2,
   parameter int CW = $clog2(B)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          en,
   output logic [CW-1:0] cnt,
   output logic          last
);

   localparam logic [CW-1:0] LAST_IDX = CW'(B - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = (cnt_q == LAST_IDX) ? '0 : cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt  = cnt_q;
   assign last = (cnt_q == LAST_IDX);

endmodule

// File: rtl/rot_loader.sv
// Assembles N-bit words from W-bit beats and presents word + rotate amount
// to the downstream combinational rotator with a valid/ready handshake.
module rot_loader
   import rot_pkg::*;
#(
   parameter int N      = N_DEFAULT,
   parameter int log2_N = LOG2_N_DEFAULT,
   parameter int W      = W_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [0:W-1]      in_data,
   input  logic [0:log2_N-1] in_k,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [0:N-1]      bits,
   output logic [0:log2_N-1] k
);

   localparam int B  = beats_per_word(N, W);
   localparam int CW = $clog2(B);

   generate
      if ((N % W) != 0 || B < 2 || N != (1 << log2_N)) begin : g_bad_params
         $error("rot_loader: need N == 2**log2_N, N %% W == 0 and N/W >= 2");
      end
   endgenerate

   rot_state_e        state_q, state_d;
   logic              out_valid_q, out_valid_d;
   logic [0:N-1]      bits_q, bits_d;
   logic [0:log2_N-1] k_q, k_d;

   logic              flush_act;
   logic              accept;
   logic [CW-1:0]     beat_cnt;
   logic              beat_last;

   // A completed word is never discarded, so flush only bites outside HOLD.
   assign flush_act = flush && (state_q != HOLD);
   assign in_ready  = !rst && !flush_act && ((state_q != HOLD) || out_ready);
   assign accept    = in_valid && in_ready;

   rot_beat_ctr #(.B(B), .CW(CW)) u_beat_ctr (
      .clk  (clk),
      .rst  (rst),
      .clr  (flush_act),
      .en   (accept),
      .cnt  (beat_cnt),
      .last (beat_last)
   );

   always_comb begin
      state_d = state_q;
      bits_d  = bits_q;
      k_d     = k_q;

      if (accept) begin
         for (int j = 0; j < B; j++) begin
            if (beat_cnt == CW'(j)) begin
               bits_d[j*W +: W] = in_data;
            end
         end
         if (beat_cnt == '0) begin
            k_d = in_k;
         end
      end

      case (state_q)
         IDLE: begin
            if (accept) state_d = LOAD;
         end
         LOAD: begin
            if (flush_act)                 state_d = IDLE;
            else if (accept && beat_last)  state_d = HOLD;
         end
         HOLD: begin
            // The counter sits at 0 here, so an accepted beat starts a new word.
            if (out_ready) state_d = accept ? LOAD : IDLE;
         end
         default: state_d = IDLE;
      endcase

      out_valid_d = (state_d == HOLD);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         out_valid_q <= 1'b0;
         bits_q      <= '0;
         k_q         <= '0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         bits_q      <= bits_d;
         k_q         <= k_d;
      end
   end

   assign out_valid = out_valid_q;
   assign bits      = bits_q;
   assign k         = k_q;

endmodule

// File: tb/tb_rot_loader.sv
// Directed bench for rot_loader (N=16, W=4) with a queue-based word model.
module tb_rot_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [0:3]  in_data;
   logic [0:3]  in_k;
   logic        out_valid;
   logic        out_ready;
   logic [0:15] bits;
   logic [0:3]  k;

   int n_cmp = 0;
   int n_bad = 0;

   rot_loader #(.N(16), .log2_N(4), .W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_k      (in_k),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .bits      (bits),
      .k         (k)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: beats collect in a queue; four of them make a word held until consumed.
   logic [3:0]  mq[$];
   bit          m_hold  = 0;
   bit          m_zero  = 0;
   bit          started = 0;
   logic [15:0] m_word;
   logic [3:0]  m_k, m_kpend;

   function automatic bit m_rdy();
      return !rst && !(flush && !m_hold) && (!m_hold || out_ready);
   endfunction

   always @(posedge clk) begin
      bit acc;
      bit was_hold;
      if (rst) begin
         mq.delete();
         m_hold  = 0;
         m_zero  = 1;
         started = 1;
      end else begin
         acc      = in_valid && m_rdy();
         was_hold = m_hold;
         if (was_hold && out_ready) m_hold = 0;
         if (flush && !was_hold) mq.delete();
         if (acc) begin
            m_zero = 0;
            if (mq.size() == 0) m_kpend = in_k;
            mq.push_back(in_data);
            if (mq.size() == 4) begin
               m_word = '0;
               foreach (mq[i]) m_word = (m_word << 4) | 16'(mq[i]);
               m_k    = m_kpend;
               m_hold = 1;
               mq.delete();
            end
         end
      end
   end

   always @(negedge clk) begin
      if (started) begin
         chk("in_ready", 32'(in_ready), 32'(m_rdy()));
         chk("out_valid", 32'(out_valid), 32'(m_hold));
         if (m_hold) begin
            chk("bits", 32'(bits), 32'(m_word));
            chk("k", 32'(k), 32'(m_k));
         end
         if (m_zero) begin
            chk("bits_rst", 32'(bits), 32'h0);
            chk("k_rst", 32'(k), 32'h0);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [3:0] d, input logic [3:0] kk);
      in_valid = 1'b1;
      in_data  = d;
      in_k     = kk;
      step();
   endtask

   task automatic word(input logic [15:0] w, input logic [3:0] k0);
      beat(w[15:12], k0);
      beat(w[11:8], 4'hF);
      beat(w[7:4], 4'hF);
      beat(w[3:0], 4'hF);
      in_valid = 1'b0;
   endtask

   initial begin
      int nov;
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_data = '0; in_k = '0;
      step(); step();
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'h0);
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_bits", 32'(bits), 32'h0);
      rst = 1'b0;

      // single word, one-cycle latency
      out_ready = 1'b1;
      beat(4'hA, 4'd3); beat(4'hB, 4'd1); beat(4'hC, 4'd2);
      in_data = 4'hD; in_k = 4'd0;
      @(negedge clk);
      chk("t1_ov_before", 32'(out_valid), 32'h0);
      step();
      in_valid = 1'b0;
      @(negedge clk);
      chk("t1_ov", 32'(out_valid), 32'h1);
      chk("t1_bits", 32'(bits), 32'hABCD);
      chk("t1_k", 32'(k), 32'h3);
      step();
      @(negedge clk);
      chk("t1_ov_drop", 32'(out_valid), 32'h0);

      // stall in HOLD, flush ignored there
      out_ready = 1'b0;
      word(16'hEF12, 4'd9);
      in_valid = 1'b1; in_data = 4'h3; in_k = 4'h0;
      for (int i = 0; i < 5; i++) begin
         flush = (i == 2);
         @(negedge clk);
         chk("t2_ov", 32'(out_valid), 32'h1);
         chk("t2_in_ready", 32'(in_ready), 32'h0);
         chk("t2_bits", 32'(bits), 32'hEF12);
         chk("t2_k", 32'(k), 32'h9);
         step();
      end
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      step();

      // back-to-back words, no bubbles
      nov = 0;
      for (int i = 0; i < 12; i++) begin
         in_valid = 1'b1;
         in_data  = 4'(i + 1);
         in_k     = 4'(i);
         @(negedge clk);
         chk("t3_in_ready", 32'(in_ready), 32'h1);
         if (i == 4) chk("t3_w1", 32'(bits), 32'h1234);
         if (i == 8) chk("t3_w2", 32'(bits), 32'h5678);
         nov += int'(out_valid);
         step();
      end
      in_valid = 1'b0;
      @(negedge clk);
      nov += int'(out_valid);
      chk("t3_w3", 32'(bits), 32'h9ABC);
      chk("t3_k3", 32'(k), 32'h8);
      chk("t3_words", 32'(nov), 32'd3);
      step();

      // flush mid-load
      beat(4'h5, 4'd1); beat(4'h6, 4'd1);
      flush = 1'b1; in_valid = 1'b1; in_data = 4'h9;
      @(negedge clk);
      chk("t4_flush_ready", 32'(in_ready), 32'h0);
      step();
      flush = 1'b0;
      word(16'h1234, 4'd7);
      @(negedge clk);
      chk("t4_bits", 32'(bits), 32'h1234);
      chk("t4_k", 32'(k), 32'h7);
      step();

      // reset in HOLD and in LOAD
      out_ready = 1'b0;
      word(16'h1111, 4'd6);
      @(negedge clk);
      chk("t5_hold", 32'(out_valid), 32'h1);
      rst = 1'b1; step(); rst = 1'b0;
      @(negedge clk);
      chk("t5_ov_a", 32'(out_valid), 32'h0);
      chk("t5_bits_a", 32'(bits), 32'h0);
      chk("t5_k_a", 32'(k), 32'h0);
      beat(4'h7, 4'd3); beat(4'h7, 4'd3);
      in_valid = 1'b0;
      rst = 1'b1; step(); rst = 1'b0;
      @(negedge clk);
      chk("t5_bits_b", 32'(bits), 32'h0);
      chk("t5_k_b", 32'(k), 32'h0);
      out_ready = 1'b1;
      word(16'h89AB, 4'd2);
      @(negedge clk);
      chk("t5_bits_c", 32'(bits), 32'h89AB);
      chk("t5_k_c", 32'(k), 32'h2);
      step();

      // k sampled only on beat 0
      word(16'hC0FE, 4'd5);
      @(negedge clk);
      chk("t6_k", 32'(k), 32'h5);
      chk("t6_bits", 32'(bits), 32'hC0FE);
      step(); step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      n_bad++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
